// File: rtl/qa_strobe_pacer_pkg.sv
// Shared constants and register decoding for the strobe pacer and its delay line.
package qa_strobe_pacer_pkg;

    localparam int RATE_OFS   = 0;
    localparam int CTRL_OFS   = 1;
    localparam int DELAY_OFS  = 2;
    localparam int LINE_DEPTH = 16;
    localparam int TAP_W      = $clog2(LINE_DEPTH);

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RATE,
        SEL_CTRL,
        SEL_DELAY
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [7:0] addr, input logic [7:0] base);
        if (addr == base + 8'(RATE_OFS))  return SEL_RATE;
        if (addr == base + 8'(CTRL_OFS))  return SEL_CTRL;
        if (addr == base + 8'(DELAY_OFS)) return SEL_DELAY;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/qa_delay_line.sv
// Valid+data shift line with DEPTH selectable taps; tap 0 is the line input itself,
// tap k is the input delayed by k cycles.
module qa_delay_line
    import qa_strobe_pacer_pkg::*;
#(
    parameter int DEPTH = LINE_DEPTH,
    parameter int WIDTH = 32,
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [TW-1:0]    tap_i,
    output logic             tap_valid_o,
    output logic [WIDTH-1:0] tap_data_o
);

    logic [DEPTH-2:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH-1];
    logic [TW-1:0]    idx;

    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // the previous stage's value from before the edge, not the freshly updated one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= {valid_q[DEPTH-3:0], in_valid_i};
        end
    end

    // NOTE: the data stages carry no reset; the valid bits alone qualify them, so
    // resetting the payload would only add reset fan-out to a wide storage array.
    always_ff @(posedge clk) begin
        data_q[0] <= in_data_i;
        for (int i = 1; i < DEPTH - 1; i++) begin
            data_q[i] <= data_q[i-1];
        end
    end

    // NOTE: every output of this always_comb is assigned on all paths (defaults
    // first), otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        idx         = tap_i - TW'(1);
        tap_valid_o = in_valid_i;
        tap_data_o  = in_data_i;
        if (tap_i != '0) begin
            tap_valid_o = valid_q[idx];
            tap_data_o  = data_q[idx];
        end
    end

endmodule

// File: rtl/qa_strobe_pacer.sv
// Paces tx_strobe sample requests at a programmable rate and returns each captured
// sample as an rx_strobe/rx_sample pair after a programmable delay.
module qa_strobe_pacer
    import qa_strobe_pacer_pkg::*;
#(
    parameter int BASE  = 12,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic             clear,
    output logic             tx_strobe,
    input  logic [WIDTH-1:0] tx_sample,
    output logic [WIDTH-1:0] rx_sample,
    output logic             rx_strobe,
    output logic [31:0]      readback
);

    reg_sel_e         sel;
    logic             enable_rise;
    logic [15:0]      rate_q, rate_d;
    logic             enable_q, enable_d;
    logic [TAP_W-1:0] delay_q, delay_d;
    logic [TAP_W-1:0] tap_q, tap_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             tx_strobe_q, tx_strobe_d;
    logic             cap_v_q, cap_v_d;
    logic             rx_strobe_q, rx_strobe_d;
    logic [WIDTH-1:0] rx_sample_q, rx_sample_d;
    logic [31:0]      readback_q, readback_d;
    logic             tap_valid;
    logic [WIDTH-1:0] tap_data;
    logic             unused_set_data;

    assign unused_set_data = ^set_data[31:16];

    always_comb begin
        sel         = set_stb ? decode_addr(set_addr, 8'(BASE)) : SEL_NONE;
        rate_d      = rate_q;
        enable_d    = enable_q;
        delay_d     = delay_q;
        tap_d       = tap_q;
        cnt_d       = cnt_q;
        tx_strobe_d = 1'b0;
        unique case (sel)
            SEL_RATE:  rate_d   = set_data[15:0];
            SEL_CTRL:  enable_d = set_data[0];
            SEL_DELAY: delay_d  = set_data[TAP_W-1:0];
            default:   ;
        endcase

        // A RATE written on a reload cycle is already the one reloaded.
        enable_rise = enable_d & ~enable_q;
        if (enable_rise) tap_d = delay_q;

        if (clear) begin
            cnt_d = rate_d;
        end else if (enable_rise || (enable_q && cnt_q == '0)) begin
            cnt_d       = rate_d;
            tx_strobe_d = 1'b1;
        end else if (enable_q) begin
            cnt_d = cnt_q - 16'd1;
        end

        cap_v_d     = tx_strobe_q & ~clear;
        rx_strobe_d = tap_valid & ~clear;
        rx_sample_d = rx_strobe_d ? tap_data : rx_sample_q;
        readback_d  = clear ? '0 : readback_q + 32'(rx_strobe_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rate_q      <= '0;
            enable_q    <= 1'b0;
            delay_q     <= '0;
            tap_q       <= '0;
            cnt_q       <= '0;
            tx_strobe_q <= 1'b0;
            cap_v_q     <= 1'b0;
            rx_strobe_q <= 1'b0;
            rx_sample_q <= '0;
            readback_q  <= '0;
        end else begin
            rate_q      <= rate_d;
            enable_q    <= enable_d;
            delay_q     <= delay_d;
            tap_q       <= tap_d;
            cnt_q       <= cnt_d;
            tx_strobe_q <= tx_strobe_d;
            cap_v_q     <= cap_v_d;
            rx_strobe_q <= rx_strobe_d;
            rx_sample_q <= rx_sample_d;
            readback_q  <= readback_d;
        end
    end

    // tx_sample is valid the cycle after tx_strobe, which is when cap_v_q is high.
    qa_delay_line #(
        .DEPTH (LINE_DEPTH),
        .WIDTH (WIDTH),
        .TW    (TAP_W)
    ) u_line (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (clear),
        .in_valid_i  (cap_v_q),
        .in_data_i   (tx_sample),
        .tap_i       (tap_q),
        .tap_valid_o (tap_valid),
        .tap_data_o  (tap_data)
    );

    assign tx_strobe = tx_strobe_q;
    assign rx_strobe = rx_strobe_q;
    assign rx_sample = rx_sample_q;
    assign readback  = readback_q;

endmodule

// File: tb/tb_qa_strobe_pacer.sv
// Randomized bench for qa_strobe_pacer: an event-level reference model predicts every
// output each cycle, and directed scenarios measure periods, latencies and counts.
module tb_qa_strobe_pacer;

    localparam int BASE  = 12;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             set_stb = 1'b0;
    logic [7:0]       set_addr = '0;
    logic [31:0]      set_data = '0;
    logic             clear = 1'b0;
    logic             tx_strobe;
    logic [WIDTH-1:0] tx_sample = '0;
    logic [WIDTH-1:0] rx_sample;
    logic             rx_strobe;
    logic [31:0]      readback;

    int n_checks = 0;
    int n_errors = 0;
    bit count_mode = 1'b0;
    logic [WIDTH-1:0] seq = '0;

    qa_strobe_pacer #(.BASE(BASE), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .set_stb   (set_stb),
        .set_addr  (set_addr),
        .set_data  (set_data),
        .clear     (clear),
        .tx_strobe (tx_strobe),
        .tx_sample (tx_sample),
        .rx_sample (rx_sample),
        .rx_strobe (rx_strobe),
        .readback  (readback)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks when the next tx strobe is due and a queue of pending
    // rx deliveries, each scheduled when its sample is captured.
    typedef struct {
        int          due;
        logic [31:0] data;
    } rx_ev_t;

    int          cyc;
    int          m_rate, m_delay, m_tap, next_tx, last_clr;
    bit          m_en;
    bit          tx_at [int];
    rx_ev_t      rxq [$];
    logic        m_tx, m_rx;
    logic [31:0] m_rxd, m_rb;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; m_rate = 0; m_delay = 0; m_tap = 0; m_en = 1'b0;
            next_tx = 0; last_clr = -1000;
            tx_at.delete(); rxq.delete();
            m_tx = 1'b0; m_rx = 1'b0; m_rxd = '0; m_rb = '0;
        end else begin
            int  nr, nd;
            bit  ne, rise;
            cyc++;
            nr = m_rate; nd = m_delay; ne = m_en;
            if (set_stb && set_addr == 8'(BASE + 0)) nr = int'(set_data[15:0]);
            if (set_stb && set_addr == 8'(BASE + 1)) ne = set_data[0];
            if (set_stb && set_addr == 8'(BASE + 2)) nd = int'(set_data[3:0]);
            rise = ne && !m_en;
            if (clear) begin
                m_tx = 1'b0; m_rx = 1'b0; m_rb = '0;
                rxq.delete();
                last_clr = cyc;
                next_tx = cyc + nr + 1;
            end else begin
                if (tx_at.exists(cyc - 2) && (cyc - 2) > last_clr) begin
                    rx_ev_t ev;
                    ev.due = cyc + m_tap;
                    ev.data = tx_sample;
                    rxq.push_back(ev);
                end
                m_tx = rise || (m_en && cyc == next_tx);
                if (m_tx) begin
                    tx_at[cyc] = 1'b1;
                    next_tx = cyc + nr + 1;
                end
                m_rx = 1'b0;
                if (rxq.size() > 0 && rxq[0].due == cyc) begin
                    m_rx = 1'b1;
                    m_rxd = rxq[0].data;
                    void'(rxq.pop_front());
                    m_rb = m_rb + 32'd1;
                end
            end
            if (rise) m_tap = m_delay;
            m_rate = nr; m_en = ne; m_delay = nd;
        end
    end

    always @(negedge clk) begin
        check("tx_strobe", tx_strobe, m_tx);
        check("rx_strobe", rx_strobe, m_rx);
        check("rx_sample", rx_sample, m_rxd);
        check("readback", readback, m_rb);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (count_mode) begin
                seq = seq + 1'b1;
                tx_sample = seq;
            end else begin
                tx_sample = $urandom;
            end
        end
    end

    task automatic write_reg(input int ofs, input logic [31:0] data);
        set_stb = 1'b1; set_addr = 8'(BASE + ofs); set_data = data;
        @(posedge clk); #1;
        set_stb = 1'b0; set_data = $urandom;
    endtask

    task automatic wait_tx(input int budget, output int t);
        bit found = 1'b0;
        t = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (tx_strobe === 1'b1) begin found = 1'b1; t = cyc; end
        end
        if (!found) check("tx_timeout", 0, 1);
    endtask

    task automatic wait_rx(input int budget, output int t);
        bit found = 1'b0;
        t = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (rx_strobe === 1'b1) begin found = 1'b1; t = cyc; end
        end
        if (!found) check("rx_timeout", 0, 1);
    endtask

    task automatic count_pulses(input int n, output int ntx, output int nrx);
        ntx = 0; nrx = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ntx += int'(tx_strobe === 1'b1);
            nrx += int'(rx_strobe === 1'b1);
        end
    endtask

    initial begin
        int t0, t1, t2, tr, ntx, nrx;
        logic [31:0] rb0;

        #23 reset_n = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(negedge clk);
        check("idle_tx", tx_strobe, 1'b0);
        check("idle_rb", readback, 32'd0);

        // RATE=63, DELAY=0: period 64, rx two cycles after tx.
        write_reg(0, 32'd63);
        write_reg(2, 32'd0);
        write_reg(1, 32'd1);
        wait_tx(5, t0);
        wait_tx(80, t1);
        wait_tx(80, t2);
        check("p64_a", t1 - t0, 64);
        check("p64_b", t2 - t1, 64);
        wait_rx(5, tr);
        check("lat_d0", tr - t2, 2);
        write_reg(1, 32'd0);
        repeat (80) @(negedge clk);

        // RATE=0, DELAY=15, counting samples: continuous stream after 17 cycles.
        count_mode = 1'b1;
        write_reg(0, 32'd0);
        write_reg(2, 32'd15);
        write_reg(1, 32'd1);
        wait_tx(5, t0);
        wait_rx(30, tr);
        check("lat_d15", tr - t0, 17);
        count_pulses(30, ntx, nrx);
        check("stream_tx", ntx, 30);
        check("stream_rx", nrx, 30);
        write_reg(1, 32'd0);
        count_mode = 1'b0;
        repeat (30) @(negedge clk);

        // RATE=9 running, RATE=3 written mid-period; DELAY=5 written while enabled.
        write_reg(0, 32'd9);
        write_reg(1, 32'd1);
        wait_tx(5, t0);
        repeat (4) @(posedge clk);
        #1;
        write_reg(0, 32'd3);
        write_reg(2, 32'd5);
        wait_tx(20, t1);
        wait_tx(20, t2);
        check("rate_old", t1 - t0, 10);
        check("rate_new", t2 - t1, 4);
        write_reg(1, 32'd0);
        repeat (30) @(negedge clk);

        // DELAY=5, three samples in flight, then disable.
        write_reg(0, 32'd1);
        write_reg(1, 32'd1);
        wait_tx(5, t0);
        wait_tx(5, t1);
        wait_tx(5, t2);
        rb0 = readback;
        write_reg(1, 32'd0);
        count_pulses(30, ntx, nrx);
        check("drain_tx", ntx, 0);
        check("drain_rx", nrx, 3);
        check("drain_rb", readback - rb0, 32'd3);

        // Clear on a counter-expiry cycle with a sample in flight.
        write_reg(0, 32'd9);
        write_reg(2, 32'd15);
        write_reg(1, 32'd1);
        wait_tx(5, t0);
        wait_tx(15, t1);
        repeat (9) @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        check("clr_tx_same", tx_strobe, 1'b0);
        check("clr_rx_same", rx_strobe, 1'b0);
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        check("clr_tx_next", tx_strobe, 1'b0);
        check("clr_rx_next", rx_strobe, 1'b0);
        check("clr_rb", readback, 32'd0);
        wait_tx(15, t2);
        check("clr_reload", t2 - t1, 20);
        wait_rx(25, tr);
        check("clr_delay_kept", tr - t2, 17);

        // Asynchronous reset mid-stream.
        wait_tx(15, t0);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx", tx_strobe, 1'b0);
        check("rst_rx", rx_strobe, 1'b0);
        check("rst_rxd", rx_sample, '0);
        check("rst_rb", readback, 32'd0);
        @(posedge clk); #3 reset_n = 1'b1;
        count_pulses(40, ntx, nrx);
        check("post_rst_tx", ntx, 0);
        check("post_rst_rx", nrx, 0);
        write_reg(1, 32'd1);
        wait_tx(5, t0);
        wait_rx(5, tr);
        check("post_rst_lat", tr - t0, 2);
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
